// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational mini-ALU between two requesters
//   req_*  : per-requester operation handshake (valid/ready, fxn, a, b)
//   alu_*  : registered select/operands to the ALU, alu_result sampled back
//   resp_* : per-requester result handshake, resp_data shared
//   busy   : state is not IDLE
module alu_share_arbiter #(
  parameter int OPW = 5,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2:0]     req_fxn0,
  input  logic [2:0]     req_fxn1,
  input  logic [OPW-1:0] req_a0,
  input  logic [OPW-1:0] req_b0,
  input  logic [OPW-1:0] req_a1,
  input  logic [OPW-1:0] req_b1,
  output logic [2:0]     alu_fxn,
  output logic [OPW-1:0] alu_a,
  output logic [OPW-1:0] alu_b,
  input  logic [OPW:0]   alu_result,
  output logic [1:0]     resp_valid,
  input  logic [1:0]     resp_ready,
  output logic [OPW:0]   resp_data,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);
  state_t state_q, state_d;
  logic last_grant_q, last_grant_d, owner_q, owner_d, g;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] fxn_q, fxn_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d;
  logic [OPW:0] data_q, data_d;
  always_comb begin
    g = &req_valid ? ~last_grant_q : req_valid[1];
    req_ready = (!rst && state_q == IDLE && req_valid[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
    state_d = state_q;
    last_grant_d = last_grant_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    fxn_d = fxn_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    if (|req_ready) begin
      state_d = EXEC;
      owner_d = g;
      last_grant_d = g;
      cnt_d = LAT_M1;
      fxn_d = g ? req_fxn1 : req_fxn0;
      a_d = g ? req_a1 : req_a0;
      b_d = g ? req_b1 : req_b0;
    end
    if (state_q == EXEC) begin
      if (cnt_q == 4'd0) begin
        data_d = alu_result;
        state_d = RESP;
      end else cnt_d = cnt_q - 4'd1;
    end
    if (state_q == RESP && resp_ready[owner_q]) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      owner_q <= 1'b0;
      cnt_q <= '0;
      fxn_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      fxn_q <= fxn_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
    end
  end
  assign alu_fxn = fxn_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign resp_data = data_q;
  assign resp_valid = state_q == RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of the arbiter with ALU_LAT=1 and ALU_LAT=4 instances
module tb_alu_share_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0] fxn0, fxn1, alu_fxn;
  logic [4:0] a0, b0, a1, b1, alu_a, alu_b;
  logic [5:0] alu_result, resp_data;
  logic busy;
  logic [1:0] req_valid_l4, req_ready_l4, resp_valid_l4, resp_ready_l4;
  logic [2:0] fxn0_l4, alu_fxn_l4;
  logic [4:0] a0_l4, b0_l4, alu_a_l4, alu_b_l4;
  logic [5:0] alu_result_l4, resp_data_l4;
  logic busy_l4;
  logic [2:0] zf = 3'd0;
  logic [4:0] zo = 5'd0;
  function automatic logic [5:0] alu_f(logic [2:0] f, logic [4:0] a, logic [4:0] b);
    return f == 3'b100 ? {5'd0, a < b} : f == 3'b101 ? {1'b0, ~(a ^ b)} : {1'b0, a} + {1'b0, b};
  endfunction
  assign alu_result = alu_f(alu_fxn, alu_a, alu_b);
  assign alu_result_l4 = alu_f(alu_fxn_l4, alu_a_l4, alu_b_l4);
  alu_share_arbiter #(.OPW(5), .ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_fxn0(fxn0), .req_fxn1(fxn1), .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
    .alu_fxn(alu_fxn), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
  );
  alu_share_arbiter #(.OPW(5), .ALU_LAT(4)) u4 (
    .clk(clk), .rst(rst), .req_valid(req_valid_l4), .req_ready(req_ready_l4),
    .req_fxn0(fxn0_l4), .req_fxn1(zf), .req_a0(a0_l4), .req_b0(b0_l4), .req_a1(zo), .req_b1(zo),
    .alu_fxn(alu_fxn_l4), .alu_a(alu_a_l4), .alu_b(alu_b_l4), .alu_result(alu_result_l4),
    .resp_valid(resp_valid_l4), .resp_ready(resp_ready_l4), .resp_data(resp_data_l4), .busy(busy_l4)
  );
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    req_valid = 2'b11; resp_ready = 2'b00;
    fxn0 = 3'b100; a0 = 5'd3; b0 = 5'd7;
    fxn1 = 3'b101; a1 = 5'd24; b1 = 5'd20;
    req_valid_l4 = 2'b00; resp_ready_l4 = 2'b00; fxn0_l4 = 3'd0; a0_l4 = 5'd0; b0_l4 = 5'd0;
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp_data", resp_data, 6'd0);
    chk("rst_alu_fxn", alu_fxn, 3'd0);
    chk("rst_alu_a", alu_a, 5'd0);
    chk("rst_alu_b", alu_b, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_busy_l4", busy_l4, 1'b0);
    @(negedge clk);
    chk("rst_hold_req_ready", req_ready, 2'b00);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("contend_grant0_first", req_ready, 2'b01);
    tick();
    @(negedge clk);
    chk("c0_busy", busy, 1'b1);
    chk("c0_alu_fxn", alu_fxn, 3'b100);
    chk("c0_alu_a", alu_a, 5'd3);
    chk("c0_resp_valid_exec", resp_valid, 2'b00);
    tick(); resp_ready = 2'b01;
    @(negedge clk);
    chk("c0_resp_valid", resp_valid, 2'b01);
    chk("c0_resp_data", resp_data, 6'd1);
    chk("c0_no_accept_in_resp", req_ready, 2'b00);
    tick(); resp_ready = 2'b00;
    @(negedge clk);
    chk("contend_grant1_second", req_ready, 2'b10);
    tick(); resp_ready = 2'b01;
    @(negedge clk);
    chk("c1_alu_fxn", alu_fxn, 3'b101);
    chk("c1_alu_a", alu_a, 5'd24);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 2'b10);
      chk("bp_resp_data", resp_data, 6'd19);
      chk("bp_req_ready", req_ready, 2'b00);
      tick();
    end
    resp_ready = 2'b10; fxn0 = 3'b000; a0 = 5'd20; b0 = 5'd15;
    @(negedge clk);
    chk("bp_resp_valid_last", resp_valid, 2'b10);
    tick(); resp_ready = 2'b00;
    @(negedge clk);
    chk("alt_grant0_after_bp", req_ready, 2'b01);
    chk("alt_busy_idle", busy, 1'b0);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    chk("add_alu_a", alu_a, 5'd20);
    chk("add_alu_b", alu_b, 5'd15);
    chk("add_alu_fxn", alu_fxn, 3'd0);
    chk("add_busy", busy, 1'b1);
    tick(); resp_ready = 2'b01;
    @(negedge clk);
    chk("add_resp_valid", resp_valid, 2'b01);
    chk("add_resp_data", resp_data, 6'd35);
    tick(); resp_ready = 2'b00;
    @(negedge clk);
    chk("add_busy_done", busy, 1'b0);
    chk("add_resp_valid_done", resp_valid, 2'b00);
    tick(); req_valid = 2'b01; a0 = 5'd1; b0 = 5'd2;
    @(negedge clk);
    chk("mid_accept", req_ready, 2'b01);
    tick(); req_valid = 2'b11;
    @(negedge clk);
    chk("mid_exec_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_resp_valid", resp_valid, 2'b00);
    chk("async_req_ready", req_ready, 2'b00);
    chk("async_alu_a", alu_a, 5'd0);
    chk("async_alu_b", alu_b, 5'd0);
    chk("async_resp_data", resp_data, 6'd0);
    tick();
    @(negedge clk);
    chk("rst_no_resp", resp_valid, 2'b00);
    chk("rst_req_ready_held", req_ready, 2'b00);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant0", req_ready, 2'b01);
    req_valid = 2'b00;
    tick(); req_valid_l4 = 2'b01; fxn0_l4 = 3'b101; a0_l4 = 5'b10101; b0_l4 = 5'b00101;
    @(negedge clk);
    chk("l4_accept", req_ready_l4, 2'b01);
    tick(); req_valid_l4 = 2'b00; a0_l4 = 5'd0; b0_l4 = 5'd31;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("l4_alu_fxn", alu_fxn_l4, 3'b101);
      chk("l4_alu_a", alu_a_l4, 5'b10101);
      chk("l4_alu_b", alu_b_l4, 5'b00101);
      chk("l4_resp_valid_exec", resp_valid_l4, 2'b00);
      tick();
    end
    resp_ready_l4 = 2'b01;
    @(negedge clk);
    chk("l4_resp_valid", resp_valid_l4, 2'b01);
    chk("l4_resp_data", resp_data_l4, 6'd15);
    tick(); resp_ready_l4 = 2'b00;
    @(negedge clk);
    chk("l4_busy_done", busy_l4, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
